code_converter_sweeper: RTL and testbench
=========================================

Name: code_converter_sweeper

Overview:
- Self-test sequencer and checker for the 7-in-1 code converter: the stimulus and response side of the converter interface, replacing manual force-constant driving.
- On `start`, drives `mode` and `data_in` into the converter for every enabled mode and every input value 0..15.
- Samples `data_out` and `valid` back, compares them against an internal golden model, and reports pass/fail, error count and the first failing vector.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before the compare cycle (legal range 0..15).
- ERR_W, 8, width of the error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; ignored while busy=1.
- mode_mask  input  8  bit m enables sweeping of mode m; sampled on the accepted start.
- data_out  input  4  converter output (combinational from mode/data_in).
- valid  input  1  converter valid flag.
- mode  output  3  mode driven to the converter.
- data_in  output  4  input vector driven to the converter.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse at end of sweep.
- pass  output  1  1 when the last sweep had zero mismatches; held until the next start.
- err_count  output  ERR_W  mismatches in the current/last sweep; saturates at all-ones.
- fail_valid  output  1  1 once a mismatch has been captured in the current/last sweep.
- fail_mode  output  3  mode of the first mismatching vector.
- fail_data_in  output  4  input of the first mismatching vector.
- fail_data_out  output  4  data_out observed at the first mismatch.

Behaviour:
- Reset values (rst=1 at clk edge): state IDLE; all outputs 0 (mode=000, data_in=0000, busy=0, done=0, pass=0, err_count=0, fail_* = 0).
- Reset mid-sweep: abort immediately to IDLE with the above values; no done pulse.
- Golden model (exp_valid, exp_out) per mode, with d = data_in:
  - 000 bin->gray: d ^ (d>>1), always valid.
  - 001 gray->bin: prefix-XOR from the MSB, always valid.
  - 010 bin->BCD: d, valid when d<=9.
  - 011 BCD->XS3: d+3, valid when d<=9.
  - 100 bin->XS3: d+3, valid when d<=9.
  - 101 XS3->bin: d-3, valid when 3<=d<=12.
  - 110 XS3->BCD: d-3, valid when 3<=d<=12.
  - 111 BCD->bin: d, valid when d<=9.
  - All arithmetic is 4-bit modulo.
- Mismatch rule: valid != exp_valid, OR (exp_valid=1 AND data_out != exp_out). data_out is don't-care when exp_valid=0.
- FSM states: IDLE, DRIVE, CHECK, ADVANCE, FINISH.
- IDLE:
  - On start=1 with mode_mask != 0: latch mask; clear err_count, fail_*, pass.
  - Load mode = lowest enabled mode and data_in = 0; busy=1 next cycle; go to DRIVE.
- IDLE with start=1 and mode_mask=0: go to FINISH. done pulses the next cycle with pass=1 and err_count=0.
- DRIVE: hold mode/data_in for SETTLE_CYCLES cycles using an internal counter, then go to CHECK. With SETTLE_CYCLES=0, go straight to CHECK.
- CHECK:
  - One cycle: compare the sampled data_out/valid against the model.
  - On mismatch: err_count+1 (saturating).
  - On the first mismatch only: fail_valid=1 and capture mode/data_in/data_out.
  - Then go to ADVANCE.
- ADVANCE:
  - If data_in < 15: data_in+1.
  - Else: data_in=0 and mode = next higher enabled mode.
  - If no higher enabled mode remains: go to FINISH. Otherwise go to DRIVE.
- Vector timing: each vector is held stable for exactly SETTLE_CYCLES+2 cycles (DRIVE + CHECK + ADVANCE update edge).
- Mode wrap: there is no wrap from 111 to 000. Mode 111 is the last mode considered.
- FINISH: done=1 for one cycle, busy=0, pass = (err_count==0); then IDLE. mode/data_in keep their last values.
- start during busy: ignored with no effect. start in the same cycle as done: ignored; it is accepted only in IDLE.

Test Plan:
- rst held 3 cycles, then released -> all outputs 0. With start=1, mask=8'h01 and a correct converter: busy high for 16*(SETTLE_CYCLES+2) cycles, one done pulse, pass=1, err_count=0, fail_valid=0.
- mask=8'hFF, correct converter -> 128 vectors. Mode sequence 000..111, data_in 0..15 within each mode; done pulse, pass=1.
- mask=8'h20 (mode 101), converter forced valid=1 for all inputs -> mismatches at d=0,1,2,13,14,15. err_count=6, pass=0; first capture fail_mode=101, fail_data_in=0000.
- mask=8'h01, converter data_out stuck at 0000 -> 15 mismatches (only d=0 matches). First capture fail_data_in=0001, fail_data_out=0000.
- start with mask=8'h00 -> done pulses 2 cycles after start, pass=1, busy never asserted. A second start pulsed mid-sweep of a mask=8'h03 run has no effect (exactly 32 vectors, one done).
- rst asserted while sweeping mode 011 at d=7 -> next cycle busy=0, mode=000, data_in=0000, no done. A fresh start then completes normally.

Source files
------------

// File: rtl/code_converter_sweeper.sv
// -----------------------------------------------------------------------------
// code_converter_sweeper
//
// Self-test sequencer and checker for the 7-in-1 code converter. A start
// request sweeps every enabled converter mode over all sixteen 4-bit input
// values. Each vector is held while the converter settles, then the
// converter's response is compared against an internal golden model. The
// block reports pass/fail, a saturating mismatch count and the first failing
// vector.
//
// Handshake: start is a one-cycle request that is honoured only in IDLE.
// busy is high from the cycle after an accepted start until the sweep ends.
// done is a one-cycle pulse in the cycle the result becomes final. start seen
// while busy, or in the done cycle, is dropped.
//
// Parameters
//   SETTLE_CYCLES  cycles each vector is held before its compare cycle (0..15)
//   ERR_W          width of the mismatch counter
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous, active-high reset
//   start          one-cycle sweep request
//   mode_mask      bit m enables mode m; sampled on the accepted start
//   data_out       converter output (combinational from mode/data_in)
//   valid          converter valid flag
//   mode           mode driven to the converter
//   data_in        input vector driven to the converter
//   busy           sweep in progress
//   done           one-cycle end-of-sweep pulse
//   pass           last sweep had zero mismatches
//   err_count      mismatches in the current/last sweep (saturating)
//   fail_valid     a mismatch has been captured in the current/last sweep
//   fail_mode      mode of the first mismatching vector
//   fail_data_in   input of the first mismatching vector
//   fail_data_out  data_out observed at the first mismatch
// -----------------------------------------------------------------------------
module code_converter_sweeper #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       mode_mask,
    input  logic [3:0]       data_out,
    input  logic             valid,
    output logic [2:0]       mode,
    output logic [3:0]       data_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [2:0]       fail_mode,
    output logic [3:0]       fail_data_in,
    output logic [3:0]       fail_data_out
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRIVE   = 3'd1,
        CHECK   = 3'd2,
        ADVANCE = 3'd3,
        FINISH  = 3'd4
    } state_t;

    // Last value of the settle counter before moving on to CHECK.
    localparam logic [3:0] SETTLE_LAST =
        (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    // With no settle time a freshly loaded vector is compared straight away.
    localparam state_t LOAD_STATE = (SETTLE_CYCLES > 0) ? DRIVE : CHECK;

    state_t     state;
    logic [7:0] mask_q;
    logic [3:0] settle_cnt;

    // -------------------------------------------------------------------------
    // Mode selection helpers
    // -------------------------------------------------------------------------
    logic [2:0] first_mode;
    logic [2:0] next_mode;
    logic       next_found;

    // Lowest enabled mode of the incoming mask: scanning downwards lets the
    // lowest set bit be the last one written.
    always_comb begin
        first_mode = 3'd0;
        for (int m = 7; m >= 0; m--) begin
            if (mode_mask[m]) begin
                first_mode = 3'(m);
            end
        end
    end

    // Lowest enabled mode strictly above the current one. There is no wrap
    // from 7 back to 0, so mode 7 never has a successor.
    always_comb begin
        next_mode  = 3'd0;
        next_found = 1'b0;
        for (int m = 7; m >= 1; m--) begin
            if (mask_q[m] && (3'(m) > mode)) begin
                next_mode  = 3'(m);
                next_found = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Golden converter model (4-bit modulo arithmetic)
    // -------------------------------------------------------------------------
    logic [3:0] exp_out;
    logic       exp_valid;
    logic       mismatch;

    always_comb begin
        exp_valid = 1'b1;
        exp_out   = data_in;
        case (mode)
            3'b000: exp_out = data_in ^ (data_in >> 1);
            // Each binary bit is the XOR of all Gray bits at and above it.
            3'b001: exp_out = {data_in[3], ^data_in[3:2], ^data_in[3:1], ^data_in[3:0]};
            3'b010,
            3'b111: exp_valid = (data_in <= 4'd9);
            3'b011,
            3'b100: begin
                exp_out   = data_in + 4'd3;
                exp_valid = (data_in <= 4'd9);
            end
            3'b101,
            3'b110: begin
                exp_out   = data_in - 4'd3;
                exp_valid = (data_in >= 4'd3) && (data_in <= 4'd12);
            end
            default: begin
                exp_valid = 1'b1;
                exp_out   = data_in;
            end
        endcase
    end

    // data_out is a don't-care whenever the model says the input is invalid.
    assign mismatch = (valid != exp_valid) || (exp_valid && (data_out != exp_out));

    // -------------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            mask_q        <= 8'd0;
            settle_cnt    <= 4'd0;
            mode          <= 3'd0;
            data_in       <= 4'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            fail_valid    <= 1'b0;
            fail_mode     <= 3'd0;
            fail_data_in  <= 4'd0;
            fail_data_out <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q        <= mode_mask;
                        settle_cnt    <= 4'd0;
                        err_count     <= '0;
                        fail_valid    <= 1'b0;
                        fail_mode     <= 3'd0;
                        fail_data_in  <= 4'd0;
                        fail_data_out <= 4'd0;
                        if (mode_mask != 8'd0) begin
                            pass    <= 1'b0;
                            mode    <= first_mode;
                            data_in <= 4'd0;
                            busy    <= 1'b1;
                            state   <= LOAD_STATE;
                        end else begin
                            // Empty sweep: report an immediate clean result.
                            pass  <= 1'b1;
                            done  <= 1'b1;
                            state <= FINISH;
                        end
                    end
                end

                DRIVE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= 4'd0;
                        state      <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end

                CHECK: begin
                    if (mismatch) begin
                        if (err_count != '1) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (!fail_valid) begin
                            fail_valid    <= 1'b1;
                            fail_mode     <= mode;
                            fail_data_in  <= data_in;
                            fail_data_out <= data_out;
                        end
                    end
                    state <= ADVANCE;
                end

                ADVANCE: begin
                    if (data_in != 4'd15) begin
                        data_in <= data_in + 4'd1;
                        state   <= LOAD_STATE;
                    end else if (next_found) begin
                        data_in <= 4'd0;
                        mode    <= next_mode;
                        state   <= LOAD_STATE;
                    end else begin
                        // Last vector of the last mode: mode/data_in keep
                        // their final values; err_count is already final.
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0);
                        state <= FINISH;
                    end
                end

                FINISH: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_code_converter_sweeper.sv
// -----------------------------------------------------------------------------
// tb_code_converter_sweeper
//
// Drives the sweeper against a behavioural converter with selectable faults.
// The expected vector stream and sweep result are derived from the converter
// rules with plain arithmetic; a negedge monitor checks every busy cycle.
// -----------------------------------------------------------------------------
module tb_code_converter_sweeper;

    localparam int S    = 2;
    localparam int HOLD = S + 2;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT
    logic       start = 1'b0;
    logic [7:0] mode_mask = 8'd0;
    logic [3:0] data_out;
    logic       valid;
    logic [2:0] mode;
    logic [3:0] data_in;
    logic       busy, done, pass;
    logic [7:0] err_count;
    logic       fail_valid;
    logic [2:0] fail_mode;
    logic [3:0] fail_data_in, fail_data_out;

    code_converter_sweeper #(.SETTLE_CYCLES(S), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mode_mask(mode_mask),
        .data_out(data_out), .valid(valid), .mode(mode), .data_in(data_in),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .fail_mode(fail_mode),
        .fail_data_in(fail_data_in), .fail_data_out(fail_data_out)
    );

    // ---------------------------------------------------------------- bookkeeping
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- converter rules
    // Returns {valid, out} straight from the conversion definitions.
    function automatic logic [4:0] gm(input int m, input int d);
        int   o;
        logic v;
        v = 1'b1;
        o = d;
        case (m)
            0: o = d ^ (d >> 1);
            1: begin
                o = 0;
                for (int b = 0; b < 4; b++) o += ($countones(d >> b) % 2) << b;
            end
            2, 7: v = (d <= 9);
            3, 4: begin o = (d + 3) % 16; v = (d <= 9); end
            5, 6: begin o = (d + 13) % 16; v = (d >= 3 && d <= 12); end
            default: ;
        endcase
        return {v, 4'(o)};
    endfunction

    // Converter under test: 0 correct, 1 valid forced high, 2 data stuck at 0,
    // 3 random per-vector corruption of valid and/or data.
    int         fault_kind = 0;
    logic       flip_v[128];
    logic [3:0] flip_d[128];

    function automatic logic [4:0] conv_out(input logic [2:0] m, input logic [3:0] d);
        logic [4:0] r;
        int         idx;
        r   = gm(int'(m), int'(d));
        idx = int'({m, d});
        case (fault_kind)
            1: r[4] = 1'b1;
            2: r[3:0] = 4'd0;
            3: begin
                r[4]   = r[4] ^ flip_v[idx];
                r[3:0] = r[3:0] ^ flip_d[idx];
            end
            default: ;
        endcase
        return r;
    endfunction

    assign {valid, data_out} = conv_out(mode, data_in);

    task automatic randomize_flips();
        for (int i = 0; i < 128; i++) begin
            flip_v[i] = ($urandom_range(0, 9) == 0);
            flip_d[i] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        end
    endtask

    // ---------------------------------------------------------------- scoreboard
    logic [6:0] exp_q[$];
    logic [7:0] exp_err;
    logic       exp_pass, exp_fv;
    logic [2:0] exp_fm;
    logic [3:0] exp_fdi, exp_fdo;
    int         busy_cycles = 0;
    int         done_cnt = 0;
    logic [6:0] mon_e;

    task automatic build_model(input logic [7:0] mask);
        logic [4:0] c, g;
        logic       mism;
        exp_q.delete();
        exp_err = 8'd0;
        exp_fv  = 1'b0;
        exp_fm  = 3'd0;
        exp_fdi = 4'd0;
        exp_fdo = 4'd0;
        for (int m = 0; m < 8; m++) begin
            if (mask[m]) begin
                for (int d = 0; d < 16; d++) begin
                    for (int k = 0; k < HOLD; k++) exp_q.push_back({3'(m), 4'(d)});
                    c    = conv_out(3'(m), 4'(d));
                    g    = gm(m, d);
                    mism = (c[4] != g[4]) || (g[4] && (c[3:0] != g[3:0]));
                    if (mism) begin
                        if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
                        if (!exp_fv) begin
                            exp_fv  = 1'b1;
                            exp_fm  = 3'(m);
                            exp_fdi = 4'(d);
                            exp_fdo = c[3:0];
                        end
                    end
                end
            end
        end
        exp_pass = (exp_err == 8'd0);
    endtask

    // Every busy cycle must present the next expected {mode, data_in}.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) begin
                busy_cycles++;
                if (exp_q.size() == 0) begin
                    chk("extra_busy_cycle", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("vector", int'({mode, data_in}), int'(mon_e));
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_while_busy", int'(busy), 0);
            end
        end
    end

    // ---------------------------------------------------------------- drivers
    task automatic run_sweep(input logic [7:0] mask, input bit second, output int lat);
        int cyc;
        bit seen;
        build_model(mask);
        busy_cycles = 0;
        done_cnt    = 0;
        @(posedge clk);
        #1;
        start     = 1'b1;
        mode_mask = mask;
        cyc  = 0;
        seen = 1'b0;
        while (cyc < HOLD * 128 + 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) start = 1'b0;
            if (second && cyc == 40) begin start = 1'b1; mode_mask = 8'hFF; end
            if (second && cyc == 41) begin start = 1'b0; mode_mask = mask; end
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        lat   = cyc;
        chk("done_seen", int'(seen), 1);
        chk("pass", int'(pass), int'(exp_pass));
        chk("err_count", int'(err_count), int'(exp_err));
        chk("fail_valid", int'(fail_valid), int'(exp_fv));
        chk("fail_mode", int'(fail_mode), int'(exp_fm));
        chk("fail_data_in", int'(fail_data_in), int'(exp_fdi));
        chk("fail_data_out", int'(fail_data_out), int'(exp_fdo));
        chk("vectors_left", exp_q.size(), 0);
        chk("busy_cycles", busy_cycles, $countones(mask) * 16 * HOLD);
        repeat (3) @(negedge clk);
        chk("done_pulses", done_cnt, 1);
    endtask

    task automatic reset_mid_sweep();
        bit found;
        fault_kind = 0;
        build_model(8'h08);
        busy_cycles = 0;
        done_cnt    = 0;
        @(posedge clk);
        #1;
        start     = 1'b1;
        mode_mask = 8'h08;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < HOLD * 16 + 10; i++) begin
            @(negedge clk);
            if (busy && mode == 3'd3 && data_in == 4'd7) begin
                found = 1'b1;
                break;
            end
        end
        chk("reached_mode3_d7", int'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_mode", int'(mode), 0);
        chk("rst_data_in", int'(data_in), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b0;
        exp_q.delete();
        repeat (4) @(negedge clk);
        chk("no_done_after_rst", done_cnt, 0);
    endtask

    // ---------------------------------------------------------------- main
    int lat;

    initial begin
        // Pin the reference rules with hand-computed values.
        chk("gm_gray_5", int'(gm(0, 5)), 'h17);
        chk("gm_g2b_0111", int'(gm(1, 7)), 'h15);
        chk("gm_xs3bcd_12", int'(gm(6, 12)), 'h19);
        chk("gm_bcdxs3_9", int'(gm(3, 9)), 'h1C);
        chk("gm_xs3bin_2_invalid", int'(gm(5, 2) >> 4), 0);
        chk("gm_binxs3_10_invalid", int'(gm(4, 10) >> 4), 0);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_mode", int'(mode), 0);
        chk("reset_data_in", int'(data_in), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_pass", int'(pass), 0);
        chk("reset_err", int'(err_count), 0);
        chk("reset_fail_valid", int'(fail_valid), 0);
        chk("reset_fail_fields", int'({fail_mode, fail_data_in, fail_data_out}), 0);

        // Single mode, correct converter.
        fault_kind = 0;
        run_sweep(8'h01, 1'b0, lat);
        chk("m01_busy_len", busy_cycles, 16 * HOLD);
        chk("m01_pass", int'(pass), 1);

        // All modes, correct converter.
        run_sweep(8'hFF, 1'b0, lat);
        chk("mff_busy_len", busy_cycles, 128 * HOLD);
        chk("mff_pass", int'(pass), 1);

        // XS3->bin with valid forced high.
        fault_kind = 1;
        run_sweep(8'h20, 1'b0, lat);
        chk("fv_err", int'(err_count), 6);
        chk("fv_pass", int'(pass), 0);
        chk("fv_fail_mode", int'(fail_mode), 5);
        chk("fv_fail_data_in", int'(fail_data_in), 0);

        // Gray encode with data stuck at zero.
        fault_kind = 2;
        run_sweep(8'h01, 1'b0, lat);
        chk("stuck_err", int'(err_count), 15);
        chk("stuck_fail_data_in", int'(fail_data_in), 1);
        chk("stuck_fail_data_out", int'(fail_data_out), 0);

        // Empty mask.
        fault_kind = 0;
        run_sweep(8'h00, 1'b0, lat);
        chk("m00_done_latency", lat, 2);
        chk("m00_pass", int'(pass), 1);

        // Second start mid-sweep is ignored.
        run_sweep(8'h03, 1'b1, lat);
        chk("m03_busy_len", busy_cycles, 32 * HOLD);

        // Reset mid-sweep, then a clean rerun.
        reset_mid_sweep();
        run_sweep(8'h08, 1'b0, lat);

        // Randomized masks and faults.
        for (int it = 0; it < 12; it++) begin
            fault_kind = int'($urandom_range(0, 3));
            if (fault_kind == 3) randomize_flips();
            run_sweep(8'($urandom_range(0, 255)), 1'b0, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
